cpu_run_ctrl: RTL and testbench

- Run/halt/single-step sequencer for the single-cycle MIPS core.
- Produces one clock-enable, cpu_en, that gates the ProgramCounter and RegisterFile updates (PC, register writes, parallel-out writes) in the divided processor clock domain.
- Inputs: a run switch, a debounced step button, a halt request and a PC-match breakpoint.
- Also counts retired instructions for display on the LCD/7-segment outputs.

---
 rtl/cpu_run_ctrl.sv | 128 ++++++++++++
 tb/tb_cpu_run_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/halt/single-step sequencer with retired-instruction counter (breakpoints: RUN_CTRL_BREAKPOINT_EN)
module cpu_run_ctrl #(
    parameter int PC_W       = 8,
    parameter int DEB_CYCLES = 16,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_sw,
    input  logic             step_key,
    input  logic             halt_req,
    input  logic [PC_W-1:0]  pc,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic             bp_valid,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic             bp_hit,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BREAK = 2'b11
    } state_t;

    localparam int DW = $clog2(DEB_CYCLES + 1);

    state_t         st;
    logic           run_q1, run_s;
    logic           key_q1, key_s;
    logic           key_db;
    logic           step_evt;
    logic [DW-1:0]  deb_cnt;
    logic           bp_match;
    logic           run_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q1   <= 1'b0;
            run_s    <= 1'b0;
            key_q1   <= 1'b0;
            key_s    <= 1'b0;
            key_db   <= 1'b1;
            deb_cnt  <= '0;
            step_evt <= 1'b0;
        end else begin
            run_q1   <= run_sw;
            run_s    <= run_q1;
            key_q1   <= step_key;
            key_s    <= key_q1;
            step_evt <= 1'b0;
            // Any cycle agreeing with the debounced level restarts the count.
            if (key_s != key_db) begin
                if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
                    key_db   <= key_s;
                    deb_cnt  <= '0;
                    step_evt <= ~key_s;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

`ifdef RUN_CTRL_BREAKPOINT_EN
    logic bp_skip;

    assign bp_match = bp_valid & (pc == bp_addr) & ~bp_skip;
    assign bp_hit   = (st == ST_BREAK);

    // Skip suppresses re-hitting the same breakpoint until the PC moves away.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bp_skip <= 1'b0;
        end else if (st == ST_RUN && run_ok && bp_match) begin
            bp_skip <= 1'b1;
        end else if (pc != bp_addr) begin
            bp_skip <= 1'b0;
        end
    end
`else
    logic unused_bp;

    assign unused_bp = ^{pc, bp_addr, bp_valid};
    assign bp_match  = 1'b0;
    assign bp_hit    = 1'b0;
`endif

    assign run_ok = run_s & ~halt_req;
    assign cpu_en = ((st == ST_RUN) & run_ok & ~bp_match) | (st == ST_STEP);
    assign state  = st;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st <= ST_HALT;
        end else begin
            case (st)
                ST_HALT: begin
                    if (run_s)         st <= ST_RUN;
                    else if (step_evt) st <= ST_STEP;
                end
                ST_RUN: begin
                    if (!run_ok)       st <= ST_HALT;
                    else if (bp_match) st <= ST_BREAK;
                end
                ST_STEP: st <= ST_HALT;
                ST_BREAK: begin
                    if (!run_s)        st <= ST_HALT;
                    else if (step_evt) st <= ST_STEP;
                end
                default: st <= ST_HALT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired <= '0;
        end else if (cpu_en) begin
            retired <= retired + 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - directed self-checking bench for cpu_run_ctrl
module tb_cpu_run_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       run_sw;
    logic       step_key;
    logic       halt_req;
    logic [7:0] pc;
    logic [7:0] bp_addr;
    logic       bp_valid;
    logic       cpu_en;
    logic [1:0] state;
    logic       bp_hit;
    logic [3:0] retired;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses;
    int found;

    cpu_run_ctrl #(.PC_W(8), .DEB_CYCLES(4), .CNT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .run_sw   (run_sw),
        .step_key (step_key),
        .halt_req (halt_req),
        .pc       (pc),
        .bp_addr  (bp_addr),
        .bp_valid (bp_valid),
        .cpu_en   (cpu_en),
        .state    (state),
        .bp_hit   (bp_hit),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    // Minimal core: PC advances on every enabled edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) pc <= 8'd0;
        else if (cpu_en) pc <= pc + 8'd1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_step(input string tag);
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            tick();
            if (state == 2'b10) found = 1;
        end
        check_eq(tag, found, 1);
    endtask

    initial begin
        rst = 1'b0; run_sw = 1'b0; step_key = 1'b1; halt_req = 1'b0;
        bp_addr = 8'd0; bp_valid = 1'b0;
        tick(); tick();
        check_eq("rst_state", state, 0);
        check_eq("rst_cpu_en", cpu_en, 0);
        check_eq("rst_bp_hit", bp_hit, 0);
        check_eq("rst_retired", retired, 0);
        rst = 1'b1;

        // Run switch latency: RUN on the 3rd edge
        run_sw = 1'b1;
        tick(); tick();
        check_eq("run_lat_e2", state, 0);
        check_eq("run_lat_en2", cpu_en, 0);
        tick();
        check_eq("run_lat_e3", state, 1);
        check_eq("run_en_e3", cpu_en, 1);
        check_eq("run_ret_e3", retired, 0);
        repeat (10) tick();
        check_eq("run_ret10", retired, 10);
        check_eq("run_pc10", pc, 10);

        // halt_req blocks the current cycle and halts on the next edge
        run_sw = 1'b0;
        tick();
        check_eq("halt_pre_ret", retired, 11);
        halt_req = 1'b1;
        #1;
        check_eq("halt_en_now", cpu_en, 0);
        tick();
        check_eq("halt_state", state, 0);
        halt_req = 1'b0;
        repeat (3) tick();
        check_eq("halt_stay", state, 0);
        check_eq("halt_ret", retired, 11);
        run_sw = 1'b1;
        tick(); tick();
        check_eq("rerun_e2", state, 0);
        tick();
        check_eq("rerun_e3", state, 1);

        // Counter wrap at CNT_W=4
        repeat (4) tick();
        check_eq("wrap_15", retired, 15);
        tick();
        check_eq("wrap_0", retired, 0);
        tick();
        check_eq("wrap_1", retired, 1);
        run_sw = 1'b0;
        repeat (3) tick();
        check_eq("stop_state", state, 0);
        check_eq("stop_ret", retired, 3);

        // Bounce then press: exactly one step
        pulses = 0;
        for (int i = 0; i < 24; i++) begin
            step_key = (i < 2) ? 1'b0 : (i == 2) ? 1'b1 : (i < 9) ? 1'b0 : 1'b1;
            tick();
            if (cpu_en) pulses++;
        end
        check_eq("step_pulses", pulses, 1);
        check_eq("step_ret", retired, 4);
        check_eq("step_state", state, 0);

        // Breakpoint
        rst = 1'b0; tick(); rst = 1'b1;
        bp_valid = 1'b1;
        run_sw = 1'b1;
`ifdef RUN_CTRL_BREAKPOINT_EN
        bp_addr = 8'h05;
        repeat (3) tick();
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (pc == 8'h05) found = 1;
            else tick();
        end
        check_eq("bp_reach", found, 1);
        check_eq("bp_en_blocked", cpu_en, 0);
        check_eq("bp_state_run", state, 1);
        tick();
        check_eq("bp_state_brk", state, 3);
        check_eq("bp_hit", bp_hit, 1);
        repeat (3) tick();
        check_eq("bp_hold", state, 3);
        check_eq("bp_hold_pc", pc, 8'h05);
        step_key = 1'b0;
        wait_step("bp_step_wait");
        step_key = 1'b1;
        tick();
        check_eq("bp_after_step", state, 0);
        check_eq("bp_after_pc", pc, 8'h06);
        tick();
        check_eq("bp_resume", state, 1);
        repeat (3) tick();
        check_eq("bp_no_rebreak", state, 1);
        check_eq("bp_resume_pc", pc, 8'h09);
        check_eq("bp_hit_clr", bp_hit, 0);
`else
        bp_addr = 8'h03;
        repeat (3) tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("nobp_state", state, 1);
            check_eq("nobp_hit", bp_hit, 0);
        end
        check_eq("nobp_pc", pc, 8'h05);
`endif
        run_sw = 1'b0;
        repeat (3) tick();
        check_eq("bp_stop", state, 0);

        // Reset in the middle of a step
        step_key = 1'b0;
        wait_step("rst_step_wait");
        check_eq("rst_step_en", cpu_en, 1);
        #2 rst = 1'b0;
        #1;
        check_eq("mid_rst_en", cpu_en, 0);
        check_eq("mid_rst_state", state, 0);
        check_eq("mid_rst_ret", retired, 0);
        check_eq("mid_rst_hit", bp_hit, 0);
        step_key = 1'b1;
        tick();
        rst = 1'b1;
        repeat (8) tick();
        check_eq("post_rst_state", state, 0);
        check_eq("post_rst_ret", retired, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
